// File: rtl/dma_bus_arbiter.sv
// CPU-side responder for the DMA bus-request protocol: issues the DMA start
// command, grants the shared bus once the CPU data access drains, and reports completion.
module dma_bus_arbiter #(
    parameter int                WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] DMA_ADDR = 16'h01F4,
    parameter logic [WORD_SIZE-1:0] DMA_LEN  = 16'd12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dma_start_int,
    input  logic                 dma_end_int,
    input  logic                 BR,
    input  logic                 cpu_d_busy,
    output logic                 BG,
    output logic                 cmd,
    output logic [WORD_SIZE-1:0] cmd_addr,
    output logic [WORD_SIZE-1:0] cmd_len,
    output logic                 cpu_hold,
    output logic                 cpu_bus_en,
    output logic                 dma_busy,
    output logic                 dma_done,
    output logic [7:0]           grant_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WAIT  = 3'd2,
        PEND  = 3'd3,
        GRANT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // End-of-transfer always wins over a concurrent bus request.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dma_start_int) state_next = CMD;
            end
            CMD: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (dma_end_int)       state_next = DONE;
                else if (BR && !cpu_d_busy) state_next = GRANT;
                else if (BR)           state_next = PEND;
            end
            PEND: begin
                if (dma_end_int)       state_next = DONE;
                else if (!BR)          state_next = WAIT;
                else if (!cpu_d_busy)  state_next = GRANT;
            end
            GRANT: begin
                if (dma_end_int)       state_next = DONE;
                else if (!BR)          state_next = WAIT;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant, command and done are flopped from the next state so they are
    // glitch-free and align exactly with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            BG        <= 1'b0;
            cmd       <= 1'b0;
            dma_done  <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            grant_cnt <= 8'd0;
        end else begin
            BG       <= (state_next == GRANT);
            cmd      <= (state_next == CMD);
            dma_done <= (state_next == DONE);
            cmd_addr <= (state_next == CMD) ? DMA_ADDR : '0;
            cmd_len  <= (state_next == CMD) ? DMA_LEN : '0;
            if ((state_next == GRANT) && (state != GRANT) && (grant_cnt != 8'hFF)) begin
                grant_cnt <= grant_cnt + 8'd1;
            end
        end
    end

    assign cpu_hold   = (state == PEND) || (state == GRANT);
    assign cpu_bus_en = !BG && !cmd;
    assign dma_busy   = (state != IDLE);

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed-vector bench for dma_bus_arbiter with hand-computed expectations.
module tb_dma_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dma_start_int;
    logic        dma_end_int;
    logic        BR;
    logic        cpu_d_busy;
    logic        BG;
    logic        cmd;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cpu_hold;
    logic        cpu_bus_en;
    logic        dma_busy;
    logic        dma_done;
    logic [7:0]  grant_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dma_bus_arbiter #(
        .WORD_SIZE(16),
        .DMA_ADDR (16'h01F4),
        .DMA_LEN  (16'd12)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dma_start_int(dma_start_int),
        .dma_end_int  (dma_end_int),
        .BR           (BR),
        .cpu_d_busy   (cpu_d_busy),
        .BG           (BG),
        .cmd          (cmd),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cpu_hold     (cpu_hold),
        .cpu_bus_en   (cpu_bus_en),
        .dma_busy     (dma_busy),
        .dma_done     (dma_done),
        .grant_cnt    (grant_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        dma_start_int = 1'b0;
        dma_end_int   = 1'b0;
        BR            = 1'b0;
        cpu_d_busy    = 1'b0;
        #23;
        check("rst_bg", BG, 0);
        check("rst_cmd", cmd, 0);
        check("rst_addr", cmd_addr, 0);
        check("rst_busen", cpu_bus_en, 1);
        check("rst_hold", cpu_hold, 0);
        check("rst_busy", dma_busy, 0);
        check("rst_cnt", grant_cnt, 0);
        reset_n = 1'b1;
        step();

        // Start command
        dma_start_int = 1'b1;
        step();
        check("cmd_on", cmd, 1);
        check("cmd_addr", cmd_addr, 16'h01F4);
        check("cmd_len", cmd_len, 12);
        check("cmd_busy", dma_busy, 1);
        check("cmd_bg", BG, 0);
        check("cmd_busen", cpu_bus_en, 0);
        dma_start_int = 1'b0;
        step();
        check("cmd_off", cmd, 0);
        check("cmd_addr0", cmd_addr, 0);

        // Immediate grant and release
        BR = 1'b1;
        step();
        check("g1_bg", BG, 1);
        check("g1_busen", cpu_bus_en, 0);
        check("g1_hold", cpu_hold, 1);
        BR = 1'b0;
        step();
        check("r1_bg", BG, 0);
        check("r1_cnt", grant_cnt, 1);

        // Grant deferred behind a busy CPU data access
        BR = 1'b1;
        cpu_d_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pend_bg", BG, 0);
            check("pend_hold", cpu_hold, 1);
        end
        cpu_d_busy = 1'b0;
        step();
        check("pend_grant", BG, 1);
        check("pend_cnt", grant_cnt, 2);
        BR = 1'b0;
        step();
        check("pend_rel", BG, 0);

        // Three cycle-stealing pulses then completion
        for (int i = 0; i < 3; i++) begin
            BR = 1'b1;
            step();
            check("cs_bg1", BG, 1);
            BR = 1'b0;
            step();
            check("cs_bg0", BG, 0);
        end
        check("cs_cnt", grant_cnt, 5);
        dma_end_int = 1'b1;
        step();
        check("end_done", dma_done, 1);
        check("end_bg", BG, 0);
        dma_end_int = 1'b0;
        step();
        check("end_done0", dma_done, 0);
        check("end_busy", dma_busy, 0);

        // Start held high: ignored once out of IDLE; end beats BR in WAIT
        dma_start_int = 1'b1;
        step();
        check("s2_cmd", cmd, 1);
        step();
        check("s2_cmd_once", cmd, 0);
        check("s2_busy", dma_busy, 1);
        dma_start_int = 1'b0;
        BR = 1'b1;
        dma_end_int = 1'b1;
        step();
        check("pri_bg", BG, 0);
        check("pri_done", dma_done, 1);
        dma_end_int = 1'b0;
        step();
        check("pri_idle", dma_busy, 0);
        step();
        check("idle_br_bg", BG, 0);
        check("idle_br_busy", dma_busy, 0);
        BR = 1'b0;

        // Counter saturation
        dma_start_int = 1'b1;
        step();
        dma_start_int = 1'b0;
        step();
        for (int i = 0; i < 260; i++) begin
            BR = 1'b1;
            step();
            BR = 1'b0;
            step();
        end
        check("sat_cnt", grant_cnt, 255);
        dma_end_int = 1'b1;
        step();
        dma_end_int = 1'b0;
        step();

        // Asynchronous reset in the middle of a grant
        dma_start_int = 1'b1;
        step();
        dma_start_int = 1'b0;
        step();
        BR = 1'b1;
        step();
        check("ar_pre_bg", BG, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_bg", BG, 0);
        check("ar_cnt", grant_cnt, 0);
        check("ar_busy", dma_busy, 0);
        check("ar_busen", cpu_bus_en, 1);
        BR = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
        dma_start_int = 1'b1;
        step();
        check("ar_cmd", cmd, 1);
        check("ar_cnt2", grant_cnt, 0);
        dma_start_int = 1'b0;
        step();
        check("ar_cmd0", cmd, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
